// File: rtl/cb_heep_reg_initiator.sv
// cb_heep_reg_initiator: turns one command at a time into a register-bus
// request, waits for the responder (or a timeout) and holds the result.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   cmd_valid_i/cmd_ready_o           command handshake
//   cmd_write_i/addr/wdata/wstrb      command fields
//   reg_valid_o/write/addr/wdata/wstrb register-bus request
//   reg_ready_i/reg_rdata_i/reg_error_i register-bus response
//   rsp_valid_o/rsp_ready_i           result handshake
//   rsp_rdata_o/error/timeout         result fields
//   busy_o                            transaction in progress
module cb_heep_reg_initiator #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_write_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [DW-1:0]   cmd_wdata_i,
    input  logic [DW/8-1:0] cmd_wstrb_i,
    output logic            reg_valid_o,
    output logic            reg_write_o,
    output logic [AW-1:0]   reg_addr_o,
    output logic [DW-1:0]   reg_wdata_o,
    output logic [DW/8-1:0] reg_wstrb_o,
    input  logic            reg_ready_i,
    input  logic [DW-1:0]   reg_rdata_i,
    input  logic            reg_error_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_error_o,
    output logic            rsp_timeout_o,
    output logic            busy_o
);

    localparam int unsigned SW      = DW / 8;
    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [15:0]     r_cnt;
    logic [DW-1:0]   r_rdata;
    logic            r_error;
    logic            r_timeout;

    logic            w_idle;
    logic            w_req;
    logic            w_rsp;
    logic            w_cmd_hs;
    logic            w_done;
    logic            w_tmo;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = (r_state == S_REQ);
    assign w_rsp    = (r_state == S_RSP);
    assign w_cmd_hs = w_idle & cmd_valid_i;
    // Completion wins over timeout when ready arrives in the last cycle.
    assign w_done   = w_req & reg_ready_i;
    assign w_tmo    = w_req & ~reg_ready_i & (r_cnt == LP_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (cmd_valid_i) w_state_nxt = S_REQ;
            S_REQ:  if (w_done || w_tmo) w_state_nxt = S_RSP;
            S_RSP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_cnt   <= '0;
        end else if (w_cmd_hs) begin
            r_write <= cmd_write_i;
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
            r_wstrb <= cmd_wstrb_i;
            r_cnt   <= '0;
        end else if (w_req && !reg_ready_i) begin
            r_cnt   <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata   <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_done) begin
            r_rdata   <= r_write ? '0 : reg_rdata_i;
            r_error   <= reg_error_i;
            r_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_timeout <= 1'b1;
        end
    end

    assign cmd_ready_o   = w_idle;
    assign busy_o        = ~w_idle;

    assign reg_valid_o   = w_req;
    assign reg_write_o   = w_req & r_write;
    assign reg_addr_o    = w_req ? r_addr : '0;
    assign reg_wdata_o   = w_req ? r_wdata : '0;
    assign reg_wstrb_o   = (w_req && r_write) ? r_wstrb : '0;

    assign rsp_valid_o   = w_rsp;
    assign rsp_rdata_o   = r_rdata;
    assign rsp_error_o   = r_error;
    assign rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_cb_heep_reg_initiator.sv
// tb_cb_heep_reg_initiator: vector table plus hand sequences for
// back-pressure and mid-transaction reset.
module tb_cb_heep_reg_initiator;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_wstrb_i = '0;
    logic        reg_valid_o;
    logic        reg_write_o;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_ready_i = 1'b0;
    logic [31:0] reg_rdata_i = '0;
    logic        reg_error_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    cb_heep_reg_initiator #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
        .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_n;
        logic        rdy;
        logic [31:0] rdata;
        logic        err;
        int          x_cycles;
        logic [31:0] x_rdata;
        logic        x_err;
        logic        x_to;
    } vec_t;

    typedef struct {
        int          cycles;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one command, plays responder, then consumes the result.
    task automatic run_vec(input vec_t v);
        int   n;
        bit   done;
        exp_t e;
        @(negedge clk_i);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_write_i = v.wr;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_wstrb_i = v.wstrb;
        sb.push_back('{cycles: v.x_cycles, rdata: v.x_rdata,
                       err: v.x_err, to: v.x_to});
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        n = 0;
        done = 0;
        while (!done && n < 20) begin
            if (reg_valid_o) begin
                if (n == 0) begin
                    chk("reg_write", reg_write_o, v.wr);
                    chk("reg_addr", reg_addr_o, v.addr);
                    chk("reg_wdata", reg_wdata_o, v.wdata);
                    chk("reg_wstrb", reg_wstrb_o, v.wr ? v.wstrb : 4'h0);
                end
                reg_ready_i = v.rdy && (n == v.wait_n);
                reg_rdata_i = v.rdata;
                reg_error_i = v.err;
                n++;
                @(posedge clk_i);
                @(negedge clk_i);
                reg_ready_i = 1'b0;
                reg_rdata_i = $urandom;
                reg_error_i = 1'b1;
            end else begin
                done = 1;
            end
        end
        chk("rsp_valid", rsp_valid_o, 1);
        chk("reg_addr_outside_req", reg_addr_o, 0);
        e = sb.pop_front();
        chk("valid_cycles", n, e.cycles);
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_error", rsp_error_o, e.err);
        chk("rsp_timeout", rsp_timeout_o, e.to);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("rsp_valid_cleared", rsp_valid_o, 0);
        chk("rsp_rdata_held", rsp_rdata_o, e.rdata);
    endtask

    vec_t vt[6];
    exp_t e;

    initial begin
        vt[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, 32'hAAAAAAAA, 0,
                  1, 32'h0, 0, 0};
        vt[1] = '{0, 32'h04, 32'h0, 4'h0, 3, 1, 32'h12345678, 0,
                  4, 32'h12345678, 0, 0};
        vt[2] = '{0, 32'h08, 32'h0, 4'hF, 1, 1, 32'h00000055, 1,
                  2, 32'h00000055, 1, 0};
        vt[3] = '{0, 32'h0C, 32'h0, 4'h0, 0, 0, 32'h11111111, 0,
                  4, 32'h0, 1, 1};
        vt[4] = '{1, 32'h20, 32'h0BADF00D, 4'h5, 3, 1, 32'h22222222, 0,
                  4, 32'h0, 0, 0};
        vt[5] = '{1, 32'h24, 32'h01020304, 4'h3, 2, 1, 32'h33333333, 1,
                  3, 32'h0, 1, 0};

        #1;
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_reg_valid", reg_valid_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_reg_addr", reg_addr_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Result back-pressure with a new command waiting.
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h30;
        sb.push_back('{cycles: 1, rdata: 32'hCAFE0001, err: 0, to: 0});
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_write_i = 1'b1;
        cmd_addr_i  = 32'h34;
        cmd_wdata_i = 32'hFEEDF00D;
        cmd_wstrb_i = 4'hC;
        chk("bp_reg_valid", reg_valid_o, 1);
        reg_ready_i = 1'b1;
        reg_rdata_i = 32'hCAFE0001;
        reg_error_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        e = sb.pop_front();
        for (int k = 0; k < 10; k++) begin
            chk("bp_cmd_ready", cmd_ready_o, 0);
            chk("bp_rsp_valid", rsp_valid_o, 1);
            chk("bp_rsp_rdata", rsp_rdata_o, e.rdata);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("bp_cmd_ready_after", cmd_ready_o, 1);
        sb.push_back('{cycles: 1, rdata: 32'h0, err: 0, to: 0});
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("bp_next_valid", reg_valid_o, 1);
        chk("bp_next_addr", reg_addr_o, 32'h34);
        chk("bp_next_wstrb", reg_wstrb_o, 4'hC);
        reg_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reg_ready_i = 1'b0;
        e = sb.pop_front();
        chk("bp_next_rsp_valid", rsp_valid_o, 1);
        chk("bp_next_rdata", rsp_rdata_o, e.rdata);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Reset pulse while the request is outstanding.
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h40;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("rr_reg_valid_before", reg_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rr_reg_valid_async", reg_valid_o, 0);
        chk("rr_rsp_valid_async", rsp_valid_o, 0);
        chk("rr_cmd_ready_async", cmd_ready_o, 1);
        chk("rr_rsp_rdata_async", rsp_rdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("rr_no_rsp", rsp_valid_o, 0);
        end
        run_vec(vt[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cb_heep_reg_initiator.md
CB_HEEP_REG_INITIATOR -- requirements
Module: cb_heep_reg_initiator

Interface
REQ-001 Parameter AW, default 32, register-bus address width.
REQ-002 Parameter DW, default 32, register-bus data width; the strobe width is DW/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum number of cycles reg_valid_o is held; legal range 1..65535.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i  in  1  command offered.
REQ-007 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-008 cmd_write_i  in  1  1 = write, 0 = read.
REQ-009 cmd_addr_i  in  AW  target byte address.
REQ-010 cmd_wdata_i  in  DW  write data.
REQ-011 cmd_wstrb_i  in  DW/8  write byte strobes.
REQ-012 reg_valid_o, reg_write_o, reg_addr_o[AW], reg_wdata_o[DW], reg_wstrb_o[DW/8]  out  register-bus request fields.
REQ-013 reg_ready_i  in  1, reg_rdata_i  in  DW, reg_error_i  in  1  register-bus response fields from the responder.
REQ-014 rsp_valid_o  out  1  result available.
REQ-015 rsp_ready_i  in  1  result consumed.
REQ-016 rsp_rdata_o  out  DW  read data.
REQ-017 rsp_error_o  out  1  bus error or timeout.
REQ-018 rsp_timeout_o  out  1  timeout occurred.
REQ-019 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, REQ and RSP; no other state is reachable.
REQ-021 cmd_ready_o SHALL equal (state == IDLE); a handshake in IDLE SHALL register all cmd_* fields and move to REQ.
REQ-022 In REQ, reg_valid_o SHALL be 1, and reg_write_o, reg_addr_o and reg_wdata_o SHALL be stable copies of the registered command.
REQ-023 reg_wstrb_o SHALL be the registered strobe for a write and all-zero for a read.
REQ-024 Outside REQ, reg_valid_o SHALL be 0 and all other reg_* outputs SHALL be 0.
REQ-025 A transaction SHALL complete in the cycle where reg_valid_o and reg_ready_i are both high.
REQ-026 On completion, reg_rdata_i (forced to 0 for a write) and reg_error_i SHALL be captured into rsp_rdata_o and rsp_error_o, rsp_timeout_o SHALL be cleared, and the FSM SHALL move to RSP.
REQ-027 The timeout counter SHALL be 16 bits, cleared on entry to REQ, and incremented each REQ cycle without reg_ready_i.
REQ-028 In a REQ cycle where the counter equals TIMEOUT_CYCLES-1 and reg_ready_i is 0, the FSM SHALL move to RSP with rsp_rdata_o=0, rsp_error_o=1 and rsp_timeout_o=1, so that reg_valid_o is high for exactly TIMEOUT_CYCLES cycles.
REQ-029 If reg_ready_i is high in the timeout cycle, normal completion SHALL take priority and no timeout SHALL be flagged.
REQ-030 In RSP, rsp_valid_o SHALL be 1 and all rsp_* outputs SHALL be stable; rsp_valid_o and rsp_ready_i both high SHALL return the FSM to IDLE.
REQ-031 Minimum latency SHALL be: command handshake at cycle N, reg_valid_o at N+1, and, if ready at N+1, rsp_valid_o at N+2; back-to-back throughput is one transaction per 3 cycles.
REQ-032 rsp_rdata_o, rsp_error_o and rsp_timeout_o SHALL hold their last values in IDLE.
REQ-033 reg_ready_i, reg_rdata_i and reg_error_i SHALL be ignored outside REQ.

Reset
REQ-034 On reset assertion, the FSM SHALL be in IDLE, the counter and all captured registers SHALL be 0, and the outputs SHALL be: cmd_ready_o=1, reg_valid_o=0, rsp_valid_o=0, busy_o=0, and all data outputs 0.
REQ-035 Reset asserted mid-transaction SHALL drop reg_valid_o and rsp_valid_o asynchronously with no response emitted; the first command after reset release SHALL be accepted normally.

Verification
REQ-036 Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, with ready in the first REQ cycle -> reg_valid_o high for 1 cycle with those values; rsp_valid_o at N+2, error=0, rdata=0.
REQ-037 Read addr=0x04 with ready after 3 wait cycles, rdata=0x12345678 -> reg_valid_o high for 4 cycles, wstrb=0; rsp_rdata_o=0x12345678.
REQ-038 Read with reg_error_i=1 at completion -> rsp_error_o=1, rsp_timeout_o=0.
REQ-039 TIMEOUT_CYCLES=4 and ready never asserted -> reg_valid_o high for exactly 4 cycles; rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0. Repeat with ready in the 4th cycle -> normal completion, no timeout.
REQ-040 rsp_ready_i held low for 10 cycles while cmd_valid_i=1 -> cmd_ready_o=0 and rsp_* stable for the whole period; the next command is accepted in the cycle after rsp_ready_i rises.
REQ-041 rst_ni pulsed low during REQ -> reg_valid_o=0 immediately and no rsp_valid_o; a following write completes correctly.
